// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the three handshakes around the memory-access stage.
//   execute -> stage : in_valid/in_ready plus the instruction fields
//   stage <-> memory : mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_rdata/mem_ack
//   stage -> writeback: out_valid/out_rd/out_reg_write/out_data/fault
// The slave modport is the stage itself. The master modport is its
// environment (execute, data memory and writeback stage taken together).
interface mem_stage_if #(
  parameter int WORD_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_is_load;
  logic                 in_is_store;
  logic [2:0]           in_funct3;
  logic [4:0]           in_rd;
  logic                 in_reg_write;
  logic [WORD_SIZE-1:0] in_alu_result;
  logic [WORD_SIZE-1:0] in_store_data;

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  logic                 out_valid;
  logic [4:0]           out_rd;
  logic                 out_reg_write;
  logic [WORD_SIZE-1:0] out_data;
  logic                 fault;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_rd, in_reg_write,
           in_alu_result, in_store_data, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_rd, out_reg_write, out_data, fault
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_rd, in_reg_write,
           in_alu_result, in_store_data, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_rd, out_reg_write, out_data, fault
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory-access stage, directly downstream of the ALU.
// Non-memory ops pass the ALU result to writeback one cycle after acceptance.
// Legal, aligned loads/stores run one request/ack transaction against data
// memory; load data is lane-selected and sign/zero-extended. Illegal or
// misaligned accesses never reach memory and produce a fault record instead.
// Ports:
//   clock   - single clock, all state on posedge
//   reset_n - asynchronous active-low reset
//   bus     - mem_stage_if.slave (execute, memory and writeback handshakes)
// WORD_SIZE: datapath width; only 32 (4 byte lanes) is supported.
module mem_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_stage_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [3:0]           r_mem_wstrb;
  logic                 r_out_valid;
  logic [4:0]           r_out_rd;
  logic                 r_out_reg_write;
  logic [WORD_SIZE-1:0] r_out_data;
  logic                 r_fault;

  // Access context held for the duration of a memory transaction.
  logic [2:0]           r_funct3;
  logic [1:0]           r_lsb;
  logic                 r_reg_write;
  logic                 r_is_store;

  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_legal;
  logic                 w_misaligned;
  logic                 w_fault;

  // Replicate store data across all lanes so the strobe alone picks the lane.
  function automatic logic [WORD_SIZE-1:0] store_wdata(input logic [1:0] size,
                                                       input logic [WORD_SIZE-1:0] data);
    logic [WORD_SIZE-1:0] res;
    case (size)
      2'b00:   res = {4{data[7:0]}};
      2'b01:   res = {2{data[15:0]}};
      2'b10:   res = data;
      default: res = {WORD_SIZE{1'b0}};
    endcase
    return res;
  endfunction

  // Byte-lane write enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_wstrb(input logic [1:0] size,
                                             input logic [1:0] lsb);
    logic [3:0] res;
    case (size)
      2'b00:   res = 4'b0001 << lsb;
      2'b01:   res = lsb[1] ? 4'b1100 : 4'b0011;
      2'b10:   res = 4'b1111;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [WORD_SIZE-1:0] load_extend(input logic [2:0] f3,
                                                       input logic [1:0] lsb,
                                                       input logic [WORD_SIZE-1:0] rdata);
    logic [WORD_SIZE-1:0] sh;
    logic [WORD_SIZE-1:0] res;
    sh = rdata >> {lsb, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = sh;
      3'b100:  res = {24'h00_0000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = {WORD_SIZE{1'b0}};
    endcase
    return res;
  endfunction

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_is_mem = bus.in_is_load || bus.in_is_store;

  // Decode legality and alignment of the presented instruction.
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    if (bus.in_is_load && bus.in_is_store) begin
      w_legal = 1'b0;
    end else if (bus.in_is_load) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end else if (bus.in_is_store) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end else begin
      w_legal = 1'b1;
    end
    // funct3[1:0] encodes access size for every legal load/store.
    case (bus.in_funct3[1:0])
      2'b01:   w_misaligned = bus.in_alu_result[0];
      2'b10:   w_misaligned = (bus.in_alu_result[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_fault = w_is_mem && (!w_legal || w_misaligned);
  end

  // Stage FSM with all bus and writeback outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= {WORD_SIZE{1'b0}};
      r_mem_wdata     <= {WORD_SIZE{1'b0}};
      r_mem_wstrb     <= 4'b0000;
      r_out_valid     <= 1'b0;
      r_out_rd        <= 5'd0;
      r_out_reg_write <= 1'b0;
      r_out_data      <= {WORD_SIZE{1'b0}};
      r_fault         <= 1'b0;
      r_funct3        <= 3'b000;
      r_lsb           <= 2'b00;
      r_reg_write     <= 1'b0;
      r_is_store      <= 1'b0;
    end else begin
      // Writeback strobes are single-cycle.
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_out_valid     <= 1'b1;
              r_out_rd        <= bus.in_rd;
              r_out_reg_write <= bus.in_reg_write;
              r_out_data      <= bus.in_alu_result;
            end else if (w_fault) begin
              r_out_valid     <= 1'b1;
              r_fault         <= 1'b1;
              r_out_rd        <= bus.in_rd;
              r_out_reg_write <= 1'b0;
              r_out_data      <= {WORD_SIZE{1'b0}};
            end else begin
              r_state     <= ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.in_is_store;
              r_mem_addr  <= {bus.in_alu_result[WORD_SIZE-1:2], 2'b00};
              r_mem_wdata <= bus.in_is_store
                             ? store_wdata(bus.in_funct3[1:0], bus.in_store_data)
                             : {WORD_SIZE{1'b0}};
              r_mem_wstrb <= bus.in_is_store
                             ? store_wstrb(bus.in_funct3[1:0], bus.in_alu_result[1:0])
                             : 4'b0000;
              r_funct3    <= bus.in_funct3;
              r_lsb       <= bus.in_alu_result[1:0];
              r_out_rd    <= bus.in_rd;
              r_reg_write <= bus.in_reg_write;
              r_is_store  <= bus.in_is_store;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          // Request fields stay put until the ack arrives.
          if (bus.mem_ack) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
            r_out_valid <= 1'b1;
            if (r_is_store) begin
              r_out_reg_write <= 1'b0;
              r_out_data      <= {WORD_SIZE{1'b0}};
            end else begin
              r_out_reg_write <= r_reg_write;
              r_out_data      <= load_extend(r_funct3, r_lsb, bus.mem_rdata);
            end
          end else begin
            r_state <= ACCESS;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = (r_state == IDLE);
  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wstrb     = r_mem_wstrb;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_reg_write = r_out_reg_write;
  assign bus.out_data      = r_out_data;
  assign bus.fault         = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Each issued instruction pushes
// its expected writeback record; a negedge monitor pops and compares whenever
// out_valid is seen. Memory-side behaviour is checked inline while driving.
module tb_mem_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic        chk_rd;
    logic        rw;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  mem_stage_if #(.WORD_SIZE(32)) bus ();

  mem_stage #(.WORD_SIZE(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count a comparison and report it when the observed value differs.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every writeback strobe must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.chk_rd) check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        check("out_reg_write", {31'd0, bus.out_reg_write}, {31'd0, e.rw});
        check("out_data", bus.out_data, e.data);
        check("fault", {31'd0, bus.fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_is_store   = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_rd         = 5'd0;
    bus.in_reg_write  = 1'b0;
    bus.in_alu_result = 32'd0;
    bus.in_store_data = 32'd0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rw,
                       input logic [31:0] addr, input logic [31:0] sdata);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
    bus.in_reg_write  = rw;
    bus.in_alu_result = addr;
    bus.in_store_data = sdata;
  endtask

  // Present a non-memory op for one edge; in_valid is left high for chaining.
  task automatic issue_alu(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    sb_q.push_back('{rd: rd, chk_rd: 1'b1, rw: rw, data: res, fault: 1'b0});
    drive(1'b0, 1'b0, 3'b000, rd, rw, res, 32'd0);
    @(posedge clock); #1;
  endtask

  // Full memory transaction; checks request fields while waiting, then acks.
  task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int waits, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_data);
    sb_q.push_back('{rd: rd, chk_rd: 1'b1, rw: ld, data: exp_data, fault: 1'b0});
    drive(ld, !ld, f3, rd, ld, addr, sdata);
    @(posedge clock); #1;
    idle();
    check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    check({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    check({tag, "_we"}, {31'd0, bus.mem_we}, {31'd0, !ld});
    check({tag, "_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, exp_wstrb});
    if (!ld) check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
    for (int i = 0; i < waits; i++) begin
      @(posedge clock); #1;
      check({tag, "_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_req_held"}, {31'd0, bus.mem_req}, 32'd1);
      check({tag, "_addr_held"}, bus.mem_addr, {addr[31:2], 2'b00});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(posedge clock); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    check({tag, "_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_wb_valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Illegal or misaligned access: no request, fault record next cycle.
  task automatic fault_op(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr);
    sb_q.push_back('{rd: 5'd0, chk_rd: 1'b0, rw: 1'b0, data: 32'd0, fault: 1'b1});
    drive(ld, st, f3, 5'd9, 1'b1, addr, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    idle();
    check({tag, "_no_req"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_fault"}, {31'd0, bus.fault}, 32'd1);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset state; a valid presented during reset must not be taken.
    bus.in_valid = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // ALU pass-through, then three back-to-back ops.
    issue_alu(5'd5, 1'b1, 32'h0000_0007);
    idle();
    check("alu_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clock); #1;
    issue_alu(5'd1, 1'b1, 32'hA5A5_0001);
    check("b2b_v1", {31'd0, bus.out_valid}, 32'd1);
    issue_alu(5'd2, 1'b0, 32'h0000_0002);
    check("b2b_v2", {31'd0, bus.out_valid}, 32'd1);
    issue_alu(5'd3, 1'b1, 32'hFFFF_FFFF);
    check("b2b_v3", {31'd0, bus.out_valid}, 32'd1);
    idle();
    @(posedge clock); #1;
    check("b2b_end", {31'd0, bus.out_valid}, 32'd0);

    // Loads: byte/half lane select with sign and zero extension.
    mem_op("lb",  1'b1, 3'b000, 5'd10, 32'h0000_0103, 32'd0, 32'h80FF_1234, 3,
           32'd0, 4'b0000, 32'hFFFF_FF80);
    mem_op("lbu", 1'b1, 3'b100, 5'd11, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1,
           32'd0, 4'b0000, 32'h0000_0080);
    mem_op("lh",  1'b1, 3'b001, 5'd12, 32'h0000_0202, 32'd0, 32'h9ABC_0000, 0,
           32'd0, 4'b0000, 32'hFFFF_9ABC);
    mem_op("lhu", 1'b1, 3'b101, 5'd13, 32'h0000_0202, 32'd0, 32'h9ABC_0000, 2,
           32'd0, 4'b0000, 32'h0000_9ABC);
    mem_op("lw",  1'b1, 3'b010, 5'd14, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0,
           32'd0, 4'b0000, 32'hDEAD_BEEF);

    // Stores: lane replication and strobes; writeback carries no write.
    mem_op("sb", 1'b0, 3'b000, 5'd0, 32'h0000_0001, 32'h1234_56AB, 32'd0, 1,
           32'hABAB_ABAB, 4'b0010, 32'd0);
    mem_op("sh", 1'b0, 3'b001, 5'd0, 32'h0000_0002, 32'h1234_56AB, 32'd0, 0,
           32'h56AB_56AB, 4'b1100, 32'd0);
    mem_op("sw", 1'b0, 3'b010, 5'd0, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 2,
           32'hCAFE_F00D, 4'b1111, 32'd0);

    // Faults: misaligned word, illegal load funct3, load+store together.
    fault_op("flw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0006);
    fault_op("fld_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
    fault_op("fldst",   1'b1, 1'b1, 3'b000, 32'h0000_0000);
    fault_op("fsh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0003);

    // Stray ack while idle must do nothing.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0;
    check("stray_no_req", {31'd0, bus.mem_req}, 32'd0);
    check("stray_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock); #1;

    // Reset mid-access: request drops asynchronously, no writeback appears.
    drive(1'b1, 1'b0, 3'b010, 5'd20, 1'b1, 32'h0000_0080, 32'd0);
    @(posedge clock); #1;
    idle();
    check("abort_req_up", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("abort_req_async", {31'd0, bus.mem_req}, 32'd0);
    check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
    mem_op("post_lw", 1'b1, 3'b010, 5'd21, 32'h0000_0084, 32'd0, 32'h0BAD_CAFE, 1,
           32'd0, 4'b0000, 32'h0BAD_CAFE);

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
